// File: rtl/adc_req_ctrl_if.sv
// Handshake bundle between adc_req_ctrl, its scan requester, the ADC delay path
// and the XRAM result writer. The controller takes the master side.
interface adc_req_ctrl_if;
    logic       start;
    logic [1:0] nch_last;
    logic [7:0] p0_out;
    logic [7:0] adc_in;
    logic       busy;
    logic       res_we;
    logic [1:0] res_addr;
    logic [7:0] res_data;
    logic       done;

    modport master (
        input  start, nch_last, adc_in,
        output p0_out, busy, res_we, res_addr, res_data, done
    );

    modport slave (
        output start, nch_last, adc_in,
        input  p0_out, busy, res_we, res_addr, res_data, done
    );
endinterface

// File: rtl/adc_req_ctrl.sv
// Fixed-latency ADC request controller: scans channels 0..nch_last, one result strobe each.
// Optional build macro ADC_REQ_AVG_EN: sample each channel twice and write the rounded mean.
module adc_req_ctrl #(
    parameter int unsigned LATENCY = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    adc_req_ctrl_if.master       bus
);

`ifdef ADC_REQ_AVG_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DRIVE2 = 3'd3,
        ST_WAIT2  = 3'd4,
        ST_WRITE  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_WRITE  = 3'd5
    } state_t;
`endif

    localparam logic [7:0] WAIT_LOAD = 8'(LATENCY - 1);

    function automatic logic [7:0] req_byte(input logic second, input logic [1:0] ch);
        return {1'b1, second, 4'b0000, ch};
    endfunction

`ifdef ADC_REQ_AVG_EN
    function automatic logic [7:0] avg_round(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b} + 9'd1;
        return sum[8:1];
    endfunction
`endif

    state_t     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [1:0] ch_q,    ch_d;
    logic [1:0] last_q,  last_d;
    logic [7:0] cap_q,   cap_d;
    logic [7:0] p0_q,    p0_d;
    logic       busy_q,  busy_d;
    logic       we_q,    we_d;
    logic [1:0] addr_q,  addr_d;
    logic [7:0] data_q,  data_d;
    logic       done_q,  done_d;

    // Next state plus output values for the cycle being entered, so every output is a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        last_d  = last_q;
        cap_d   = cap_q;
        p0_d    = 8'h00;
        we_d    = 1'b0;
        done_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    last_d  = bus.nch_last;
                    ch_d    = 2'd0;
                    p0_d    = req_byte(1'b0, 2'd0);
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                cnt_d   = WAIT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 8'd0) begin
                    cap_d = bus.adc_in;
`ifdef ADC_REQ_AVG_EN
                    p0_d    = req_byte(1'b1, ch_q);
                    state_d = ST_DRIVE2;
`else
                    we_d    = 1'b1;
                    addr_d  = ch_q;
                    data_d  = bus.adc_in;
                    done_d  = (ch_q == last_q);
                    state_d = ST_WRITE;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
`ifdef ADC_REQ_AVG_EN
            ST_DRIVE2: begin
                cnt_d   = WAIT_LOAD;
                state_d = ST_WAIT2;
            end
            ST_WAIT2: begin
                if (cnt_q == 8'd0) begin
                    we_d    = 1'b1;
                    addr_d  = ch_q;
                    data_d  = avg_round(cap_q, bus.adc_in);
                    done_d  = (ch_q == last_q);
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
`endif
            ST_WRITE: begin
                if (ch_q == last_q) begin
                    state_d = ST_IDLE;
                end else begin
                    ch_d    = ch_q + 2'd1;
                    p0_d    = req_byte(1'b0, ch_q + 2'd1);
                    state_d = ST_DRIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset also discards any response still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            ch_q    <= 2'd0;
            last_q  <= 2'd0;
            cap_q   <= 8'h00;
            p0_q    <= 8'h00;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 2'd0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
            cap_q   <= cap_d;
            p0_q    <= p0_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign bus.p0_out   = p0_q;
    assign bus.busy     = busy_q;
    assign bus.res_we   = we_q;
    assign bus.res_addr = addr_q;
    assign bus.res_data = data_q;
    assign bus.done     = done_q;

endmodule
